// File: rtl/tagram_pkg.sv
// Shared defaults and state type for the tag RAM sweep controller.
package tagram_pkg;

    localparam int TAGRAM_DEPTH = 64;
    localparam int TAGRAM_WIDTH = 22;
    localparam int TAGRAM_AW    = $clog2(TAGRAM_DEPTH);

    typedef enum logic {CLEAR, RUN} tagram_state_t;

endpackage

// File: rtl/tagram_sweep_ctrl.sv
// Request front end for the 64x22 tag SRAM: registered active-low macro pins,
// zeroing sweep after reset, optional flush sweep under TAGRAM_FLUSH_EN.
module tagram_sweep_ctrl
    import tagram_pkg::*;
#(
    parameter int DEPTH = TAGRAM_DEPTH,
    parameter int WIDTH = TAGRAM_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqWrite,
    input  logic [AW-1:0]    ReqAdr,
    input  logic [WIDTH-1:0] ReqData,
    input  logic [WIDTH-1:0] ReqBitMask,
    output logic             RspValid,
    output logic [WIDTH-1:0] RspData,
    output logic             SweepBusy,
`ifdef TAGRAM_FLUSH_EN
    input  logic             FlushReq,
`endif
    output logic             CEB,
    output logic             WEB,
    output logic [AW-1:0]    A,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] BWEB,
    input  logic [WIDTH-1:0] Q
);

    tagram_state_t    state, state_nxt;
    logic [AW-1:0]    sweep_cnt, sweep_cnt_nxt;
    logic             ceb_nxt, web_nxt;
    logic [AW-1:0]    a_nxt;
    logic [WIDTH-1:0] d_nxt, bweb_nxt;
    logic             flush;
    logic             rd_issue;
    logic [2:1]       vld_pipe;
    logic [WIDTH-1:0] rsp_hold;

`ifdef TAGRAM_FLUSH_EN
    assign flush = FlushReq;
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        ReqReady      = 1'b0;
        SweepBusy     = 1'b0;
        ceb_nxt       = 1'b1;
        web_nxt       = 1'b1;
        a_nxt         = A;
        d_nxt         = D;
        bweb_nxt      = '1;
        case (state)
            CLEAR: begin
                SweepBusy = 1'b1;
                ceb_nxt   = 1'b0;
                web_nxt   = 1'b0;
                a_nxt     = sweep_cnt;
                d_nxt     = '0;
                bweb_nxt  = '0;
                if (sweep_cnt == AW'(DEPTH - 1)) begin
                    state_nxt     = RUN;
                    sweep_cnt_nxt = '0;
                end else begin
                    sweep_cnt_nxt = sweep_cnt + 1'b1;
                end
            end
            RUN: begin
                ReqReady = ~flush;
                if (flush) begin
                    state_nxt = CLEAR;
                end else if (ReqValid) begin
                    ceb_nxt = 1'b0;
                    a_nxt   = ReqAdr;
                    if (ReqWrite) begin
                        web_nxt  = 1'b0;
                        d_nxt    = ReqData;
                        bweb_nxt = ~ReqBitMask;
                    end
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign rd_issue = ReqReady & ReqValid & ~ReqWrite;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            CEB       <= 1'b1;
            WEB       <= 1'b1;
            A         <= '0;
            D         <= '0;
            BWEB      <= '1;
            vld_pipe  <= '0;
            rsp_hold  <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
            CEB       <= ceb_nxt;
            WEB       <= web_nxt;
            A         <= a_nxt;
            D         <= d_nxt;
            BWEB      <= bweb_nxt;
            vld_pipe  <= {vld_pipe[1], rd_issue};
            if (vld_pipe[2])
                rsp_hold <= Q;
        end
    end

    // Q is live only in the strobe cycle; the hold register covers all others.
    assign RspValid = vld_pipe[2];
    assign RspData  = vld_pipe[2] ? Q : rsp_hold;

endmodule
